// File: rtl/zion_basic_circuit_lib_pipe_ctrl_pkg.sv
// Shared types and width helpers for the pipeline controller.
package zion_basic_circuit_lib_pipe_ctrl_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } pipe_ctrl_state_e;

    localparam int DEF_STAGES   = 3;
    localparam int DEF_HOLD_CYC = 2;

    // Bits needed to count 0..n inclusive, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/zion_basic_circuit_lib_pipe_ctrl_hold_cnt.sv
// Loadable down-counter that times the upstream hold-off after a flush.
module zion_basic_circuit_lib_pipe_ctrl_hold_cnt #(
    parameter int HOLD_CYC = 2,
    parameter int W        = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    // Load wins over decrement; the count saturates at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= W'(HOLD_CYC);
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/zion_basic_circuit_lib_pipe_ctrl.sv
// Control for a chain of clearable pipeline registers: per-stage enables,
// clears, valid bits, occupancy and a flush/hold-off sequencer.
module zion_basic_circuit_lib_pipe_ctrl
    import zion_basic_circuit_lib_pipe_ctrl_pkg::*;
#(
    parameter int STAGES   = DEF_STAGES,
    parameter int HOLD_CYC = DEF_HOLD_CYC,
    parameter int CNT_W    = cnt_width(STAGES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iVld,
    output logic              oRdy,
    output logic              oVld,
    input  logic              iRdy,
    input  logic              iFlush,
    output logic [STAGES-1:0] oEn,
    output logic [STAGES-1:0] oClr,
    output logic [STAGES-1:0] oStgVld,
    output logic [CNT_W-1:0]  oCnt,
    output logic              oBusy
);

    localparam int HOLD_W = cnt_width(HOLD_CYC);

    generate
        if (STAGES < 1) begin : g_param_check
`ifdef CHECK_ERR_EXIT
            $fatal(1, "zion_basic_circuit_lib_pipe_ctrl: STAGES must be >= 1");
`else
            $error("zion_basic_circuit_lib_pipe_ctrl: STAGES must be >= 1");
`endif
        end
    endgenerate

    pipe_ctrl_state_e  state;
    logic [STAGES-1:0] v;
    logic [STAGES-1:0] adv;
    logic [HOLD_W-1:0] hold_cnt;
    logic              hold_zero;
    logic              hold_last;
    logic              live;
    logic              accept;
    logic              retire;

    // A stage may load when it is empty or its occupant moves on, so bubbles collapse
    always_comb begin
        adv = '0;
        adv[STAGES-1] = ~v[STAGES-1] | iRdy;
        for (int i = STAGES - 2; i >= 0; i--) begin
            adv[i] = ~v[i] | adv[i+1];
        end
    end

    assign live    = (state == RUN) & ~iFlush;
    assign oEn     = adv & {STAGES{live}};
    assign oClr    = {STAGES{(state == RUN) & iFlush}};
    assign oRdy    = adv[0] & live;
    assign oVld    = v[STAGES-1] & live;
    assign oStgVld = v;
    assign oBusy   = (state == HOLD);
    assign accept  = iVld & oRdy;
    assign retire  = oVld & iRdy;

    generate
        if (HOLD_CYC > 0) begin : g_hold
            zion_basic_circuit_lib_pipe_ctrl_hold_cnt #(
                .HOLD_CYC (HOLD_CYC),
                .W        (HOLD_W)
            ) u_hold_cnt (
                .clk  (clk),
                .rst  (rst),
                .load (iFlush),
                .dec  ((state == HOLD) & ~iFlush),
                .cnt  (hold_cnt),
                .zero (hold_zero)
            );
        end else begin : g_no_hold
            assign hold_cnt  = '0;
            assign hold_zero = 1'b1;
        end
    endgenerate

    assign hold_last = (hold_cnt == HOLD_W'(1));

    // Sequencer, valid bits and occupancy share one register block
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            v     <= '0;
            oCnt  <= '0;
        end else if (state == RUN) begin
            if (iFlush) begin
                v    <= '0;
                oCnt <= '0;
                if (HOLD_CYC > 0) begin
                    state <= HOLD;
                end
            end else begin
                if (adv[0]) begin
                    v[0] <= accept;
                end
                for (int i = 1; i < STAGES; i++) begin
                    if (adv[i]) begin
                        v[i] <= v[i-1];
                    end
                end
                oCnt <= oCnt + CNT_W'(accept) - CNT_W'(retire);
            end
        end else begin
            // A flush while holding restarts the timer rather than releasing
            if (!iFlush && (hold_last || hold_zero)) begin
                state <= RUN;
            end
        end
    end

endmodule

// File: tb/tb_zion_basic_circuit_lib_pipe_ctrl.sv
// Self-checking bench: slot-level pipeline model plus a scratch datapath driven by oEn/oClr.
module tb_zion_basic_circuit_lib_pipe_ctrl;

    localparam int STAGES   = 3;
    localparam int HOLD_CYC = 2;
    localparam int CNT_W    = 2;

    logic              clk;
    logic              rst;
    logic              iVld;
    logic              oRdy;
    logic              oVld;
    logic              iRdy;
    logic              iFlush;
    logic [STAGES-1:0] oEn;
    logic [STAGES-1:0] oClr;
    logic [STAGES-1:0] oStgVld;
    logic [CNT_W-1:0]  oCnt;
    logic              oBusy;

    logic [7:0] din;
    logic [7:0] dp [STAGES];

    int checks;
    int fails;

    bit         mfull [STAGES];
    logic [7:0] mdata [STAGES];
    bit         mhold;
    int         hold_rem;
    logic [7:0] next_word;

    zion_basic_circuit_lib_pipe_ctrl #(
        .STAGES   (STAGES),
        .HOLD_CYC (HOLD_CYC),
        .CNT_W    (CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .iVld    (iVld),
        .oRdy    (oRdy),
        .oVld    (oVld),
        .iRdy    (iRdy),
        .iFlush  (iFlush),
        .oEn     (oEn),
        .oClr    (oClr),
        .oStgVld (oStgVld),
        .oCnt    (oCnt),
        .oBusy   (oBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data-only registers obeying the controller, so ordering of words is observable
    always @(posedge clk) begin
        for (int i = 0; i < STAGES; i++) begin
            if (oClr[i]) dp[i] <= '0;
            else if (oEn[i]) dp[i] <= (i == 0) ? din : dp[i-1];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < STAGES; i++) begin
            mfull[i] = 1'b0;
            mdata[i] = '0;
        end
        mhold    = 1'b0;
        hold_rem = 0;
    endtask

    // One clock cycle: drive, check all outputs against the model at negedge, advance
    task automatic applyStimulus(input bit vld, input bit rdy, input bit flush);
        bit               nf [STAGES];
        logic [7:0]       nd [STAGES];
        bit               leaves [STAGES];
        logic [STAGES-1:0] e_en;
        logic [STAGES-1:0] e_stg;
        bit               run_ok;
        bit               space;
        int               occ;
        iVld   = vld;
        iRdy   = rdy;
        iFlush = flush;
        din    = next_word;
        #4;
        occ = 0;
        for (int i = 0; i < STAGES; i++) begin
            nf[i] = mfull[i];
            nd[i] = mdata[i];
            leaves[i] = 1'b0;
            e_stg[i] = mfull[i];
            if (mfull[i]) occ++;
        end
        // Sweep from the output end: the last word leaves, then each word steps into a free slot
        if (nf[STAGES-1] && rdy) begin
            nf[STAGES-1] = 1'b0;
            leaves[STAGES-1] = 1'b1;
        end
        for (int i = STAGES - 2; i >= 0; i--) begin
            if (nf[i] && !nf[i+1]) begin
                nf[i+1] = 1'b1;
                nd[i+1] = nd[i];
                nf[i] = 1'b0;
                leaves[i] = 1'b1;
            end
        end
        space  = !nf[0];
        run_ok = !mhold && !flush;
        for (int i = 0; i < STAGES; i++) e_en[i] = run_ok && (!mfull[i] || leaves[i]);
        checkOutput("oRdy", oRdy, run_ok && space);
        checkOutput("oVld", oVld, run_ok && mfull[STAGES-1]);
        checkOutput("oEn", oEn, e_en);
        checkOutput("oClr", oClr, (!mhold && flush) ? 3'b111 : 3'b000);
        checkOutput("oStgVld", oStgVld, e_stg);
        checkOutput("oCnt", oCnt, occ);
        checkOutput("oBusy", oBusy, mhold);
        if (run_ok && mfull[STAGES-1] && rdy) checkOutput("data_out", dp[STAGES-1], mdata[STAGES-1]);
        if (mhold) begin
            if (flush) hold_rem = HOLD_CYC;
            else begin
                hold_rem--;
                if (hold_rem == 0) mhold = 1'b0;
            end
        end else if (flush) begin
            for (int i = 0; i < STAGES; i++) mfull[i] = 1'b0;
            hold_rem = HOLD_CYC;
            mhold = (HOLD_CYC > 0);
        end else begin
            mfull = nf;
            mdata = nd;
            if (space && vld) begin
                mfull[0] = 1'b1;
                mdata[0] = din;
                next_word++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        next_word = 8'd1;
        modelReset();
        rst = 1'b1;
        iVld = 1'b0;
        iRdy = 1'b0;
        iFlush = 1'b0;
        din = '0;
        #2;
        checkOutput("rst_oVld", oVld, 0);
        checkOutput("rst_oStgVld", oStgVld, 0);
        checkOutput("rst_oCnt", oCnt, 0);
        checkOutput("rst_oBusy", oBusy, 0);
        checkOutput("rst_oClr", oClr, 0);
        checkOutput("rst_oRdy", oRdy, 1);
        checkOutput("rst_oEn", oEn, 3'b111);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Streaming ten words then drain
        for (int i = 0; i < 10; i++) applyStimulus(1, 1, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0);

        // Backpressure fill, then release in the same cycle
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0);
        checkOutput("bp_cnt", oCnt, 3);
        checkOutput("bp_rdy_low", oRdy, 0);
        iRdy = 1'b1;
        #1;
        checkOutput("bp_rdy_same_cycle", oRdy, 1);
        applyStimulus(1, 1, 0);
        applyStimulus(1, 1, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0);

        // Bubble collapse toward the stalled output
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 0);
        checkOutput("bubble_stg", oStgVld, 3'b110);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0);

        // Flush a full pipe, then hold-off
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 1);
        checkOutput("flush_busy", oBusy, 1);
        checkOutput("flush_cnt", oCnt, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0);

        // Second flush on the first hold cycle
        applyStimulus(1, 0, 1);
        applyStimulus(1, 0, 1);
        for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0);

        // Randomized traffic with occasional flushes
        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 20) == 0);
        end
        for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0);

        // Asynchronous reset between edges with a full pipe
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0);
        iVld = 1'b0;
        iFlush = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_oVld", oVld, 0);
        checkOutput("arst_oStgVld", oStgVld, 0);
        checkOutput("arst_oCnt", oCnt, 0);
        checkOutput("arst_oBusy", oBusy, 0);
        modelReset();
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) applyStimulus(1, 1, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
